// File: rtl/codeword_deser.sv
// codeword_deser
//   Serial-to-parallel front end for the codeword decoder. A strobed,
//   LSB-first serial stream is assembled into WORD_W-bit codewords, which
//   are queued in a DEPTH-entry FIFO and presented on a valid/ready port.
//   Framing errors (SOF while mid-word) and overruns (word completes into a
//   full FIFO with no pop) are reported through sticky flags.
//
// Optional feature macro: DESER_ERRCNT_EN
//   defined   -> 8-bit saturating error counter driven on err_cnt_o
//   undefined -> counter omitted, err_cnt_o tied to 0
//
// Ports
//   wb_clk_i      clock
//   wb_rst_i      asynchronous active-high reset
//   ser_valid_i   one-cycle strobe qualifying ser_data_i / ser_sof_i
//   ser_data_i    serial data bit
//   ser_sof_i     start of frame, marks bit 0 of a word
//   word_o        registered FIFO head (0 when empty)
//   word_valid_o  FIFO not empty
//   word_ready_i  decoder accepts the head word
//   frame_err_o   sticky framing-error flag
//   overrun_o     sticky overrun flag
//   err_clr_i     synchronous clear of flags and counter
//   err_cnt_o     saturating error count
module codeword_deser #(
  parameter int WORD_W = 7,
  parameter int DEPTH  = 2
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic              ser_valid_i,
  input  logic              ser_data_i,
  input  logic              ser_sof_i,
  output logic [WORD_W-1:0] word_o,
  output logic              word_valid_o,
  input  logic              word_ready_i,
  output logic              frame_err_o,
  output logic              overrun_o,
  input  logic              err_clr_i,
  output logic [7:0]        err_cnt_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int BW = $clog2(WORD_W);

  typedef enum logic {IDLE, COLLECT} state_t;

  state_t            state;
  logic [BW-1:0]     bcnt;
  logic [WORD_W-1:0] shreg;

  logic [WORD_W-1:0] mem [DEPTH];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;

  logic              last_bit;
  logic              word_done;
  logic              frame_ev;
  logic              overrun_ev;
  logic              fifo_full;
  logic              fifo_empty;
  logic              push;
  logic              pop;
  logic [WORD_W-1:0] push_word;
  logic [PW-1:0]     wr_next;
  logic [PW-1:0]     rd_next;
  logic              empty_next;
  logic [WORD_W-1:0] head_next;

  // Event decode. The final bit is never written into shreg; the pushed
  // word is formed directly from the strobe so it lands in the FIFO on
  // the same edge.
  always_comb begin
    last_bit   = (bcnt == BW'(WORD_W - 1));
    word_done  = ser_valid_i && !ser_sof_i && (state == COLLECT) && last_bit;
    frame_ev   = ser_valid_i && ser_sof_i && (state == COLLECT);
    fifo_empty = (wr_ptr == rd_ptr);
    // Pointer MSBs differ with equal indices only when full.
    fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                 (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    pop        = !fifo_empty && word_ready_i;
    push       = word_done && (!fifo_full || pop);
    overrun_ev = word_done && fifo_full && !pop;
    push_word  = {ser_data_i, shreg[WORD_W-2:0]};
  end

  // Next FIFO head, used to keep word_o a true register. A push only
  // becomes the head when it is written into the slot the read pointer
  // will point at (the FIFO was empty, or emptied by this cycle's pop).
  always_comb begin
    wr_next    = wr_ptr + PW'(push);
    rd_next    = rd_ptr + PW'(pop);
    empty_next = (wr_next == rd_next);
    if (push && (wr_ptr[AW-1:0] == rd_next[AW-1:0]))
      head_next = push_word;
    else
      head_next = mem[rd_next[AW-1:0]];
  end

  // Collection FSM. SOF always restarts a word with bcnt=1, whether it
  // arrives in IDLE (normal start) or COLLECT (framing error).
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state <= IDLE;
      bcnt  <= '0;
      shreg <= '0;
    end else if (ser_valid_i) begin
      if (ser_sof_i) begin
        shreg <= {{(WORD_W-1){1'b0}}, ser_data_i};
        bcnt  <= BW'(1);
        state <= COLLECT;
      end else if (state == COLLECT) begin
        if (last_bit) begin
          bcnt  <= '0;
          state <= IDLE;
        end else begin
          shreg[bcnt] <= ser_data_i;
          bcnt        <= bcnt + BW'(1);
        end
      end
    end
  end

  // Output FIFO with registered head and valid.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      for (int i = 0; i < DEPTH; i++)
        mem[i] <= '0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      word_o       <= '0;
      word_valid_o <= 1'b0;
    end else begin
      if (push)
        mem[wr_ptr[AW-1:0]] <= push_word;
      wr_ptr       <= wr_next;
      rd_ptr       <= rd_next;
      word_valid_o <= !empty_next;
      word_o       <= empty_next ? '0 : head_next;
    end
  end

  // Sticky flags: a new event takes priority over a same-cycle clear.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      frame_err_o <= 1'b0;
      overrun_o   <= 1'b0;
    end else begin
      if (frame_ev)
        frame_err_o <= 1'b1;
      else if (err_clr_i)
        frame_err_o <= 1'b0;
      if (overrun_ev)
        overrun_o <= 1'b1;
      else if (err_clr_i)
        overrun_o <= 1'b0;
    end
  end

`ifdef DESER_ERRCNT_EN
  // Frame and overrun events are mutually exclusive (SOF vs non-SOF
  // strobe), so at most one increment per cycle. Clear plus event gives 1.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      err_cnt_o <= '0;
    end else if (frame_ev || overrun_ev) begin
      if (err_clr_i)
        err_cnt_o <= 8'd1;
      else if (err_cnt_o != 8'hFF)
        err_cnt_o <= err_cnt_o + 8'd1;
    end else if (err_clr_i) begin
      err_cnt_o <= '0;
    end
  end
`else
  assign err_cnt_o = '0;
`endif

endmodule

// File: doc/codeword_deser.md
# codeword_deser

Serial-to-parallel front end for the codeword decoder. Collects a strobed, LSB-first serial bit stream into 7-bit codewords and buffers them in a 2-entry FIFO. Presents each codeword on a valid/ready port that drives the decoder's 7-bit `io_in` input. Flags framing errors and overruns so firmware can detect lost words.

## Interface
- `WORD_W`, default 7: codeword width; must match the decoder input width.
- `DEPTH`, default 2: output FIFO depth; power of two, at least 2.
- `wb_clk_i` in 1: single clock.
- `wb_rst_i` in 1: asynchronous, active-high reset.
- `ser_valid_i` in 1: one-cycle strobe marking a valid serial bit.
- `ser_data_i` in 1: serial bit, sampled when `ser_valid_i` is high.
- `ser_sof_i` in 1: start of frame; qualifies the first bit of a word and is sampled only with `ser_valid_i`.
- `word_o` out WORD_W: head-of-FIFO codeword to the decoder.
- `word_valid_o` out 1: FIFO not empty.
- `word_ready_i` in 1: decoder accepts the word.
- `frame_err_o` out 1: sticky framing-error flag.
- `overrun_o` out 1: sticky overrun flag.
- `err_clr_i` in 1: synchronous clear of both sticky flags and the error counter.
- `err_cnt_o` out 8: saturating error count (see Configuration).

## Operation
- The FSM has two states, IDLE and COLLECT. It uses a 3-bit bit counter `bcnt` and a WORD_W shift register.
- IDLE:
  - A strobe with `ser_sof_i=1` loads bit 0, sets `bcnt=1` and moves to COLLECT.
  - A strobe with `ser_sof_i=0` is ignored (line noise). It is not counted as an error.
- COLLECT:
  - Each strobe with `ser_sof_i=0` stores `ser_data_i` at bit position `bcnt` and increments `bcnt`.
  - Bits are LSB-first, so the bit at `bcnt=k` lands in `word[k]`.
  - On the strobe that fills bit WORD_W-1, the assembled word is pushed to the FIFO and the FSM returns to IDLE.
- Framing error: a strobe with `ser_sof_i=1` while in COLLECT.
  - The partial word is discarded and `frame_err_o` is set.
  - The error counter increments.
  - The new bit is treated as bit 0 of a fresh word, so the FSM stays in COLLECT with `bcnt=1`.
- Overrun: a word completes while the FIFO is full and no pop happens in the same cycle.
  - The new word is dropped, `overrun_o` is set and the error counter increments.
  - The FIFO contents are untouched.
- Pop: when `word_valid_o` and `word_ready_i` are both high at a clock edge, the head entry is removed.
- Push and pop in the same cycle are always legal:
  - When full, the push is accepted and the occupancy is unchanged.
  - When empty, the push completes first and the word becomes visible the next cycle. There is no bypass.
- FIFO pointers are log2(DEPTH)+1 bits. Full and empty are distinguished by the MSB; the pointers wrap naturally.
- `err_clr_i` clears `frame_err_o`, `overrun_o` and `err_cnt_o`.
  - If an error event occurs in the same cycle as the clear, the set wins: the flag ends up at 1 and the counter at 1.
- Reset state:
  - FSM in IDLE, `bcnt=0`, shift register 0, FIFO empty.
  - Outputs: `word_o=0`, `word_valid_o=0`, `frame_err_o=0`, `overrun_o=0`, `err_cnt_o=0`.
- Reset asserted mid-word discards the partial word and all buffered words immediately (asynchronously).

## Timing
- Latency: `word_valid_o` rises on the first edge after the final-bit strobe, i.e. one cycle later.
- `word_o` is registered and driven from the FIFO head.
  - It holds stable while `word_valid_o=1` and `word_ready_i=0`.
  - It reads 0 when the FIFO is empty.
- Strobes may arrive on consecutive cycles. Sustained throughput is one word per WORD_W cycles.
- Sticky flags and the counter update on the same edge as the triggering strobe.
- All outputs are registered; there are no combinational paths from input to output.
- Reset deassertion is synchronous to `wb_clk_i` by the integrator; the block only requires the asynchronous assert.

## Configuration
- `DESER_ERRCNT_EN` defined:
  - An 8-bit counter increments once per framing or overrun event and saturates at 255.
  - It is cleared by `err_clr_i`, and is driven on `err_cnt_o`.
- `DESER_ERRCNT_EN` undefined:
  - The counter logic is omitted and `err_cnt_o` is tied to 0.
  - The sticky flags behave identically in both builds.

## Test plan
- **Basic word:** after reset, strobe SOF plus the bits 1,0,1,0,0,0,1 on consecutive cycles with `word_ready_i=0` -> `word_valid_o` rises one cycle after the last strobe with `word_o=7'b1000101`.
- **Back-pressure and overrun:**
  - Send three words 0x45, 0x12, 0x7F with `word_ready_i=0` -> first two buffered, third dropped, `overrun_o=1`, `err_cnt_o=1`.
  - Then raise `word_ready_i` -> words pop as 0x45 then 0x12.
- **Framing error:** SOF, 3 bits, SOF, then 6 bits forming 0x2A -> `frame_err_o=1`, a single word 0x2A is output, and `err_cnt_o=1`.
- **Simultaneous events:**
  - FIFO full, word completes while `word_ready_i=1` -> no overrun and occupancy stays 2.
  - `err_clr_i` in the same cycle as a framing error -> `frame_err_o=1`, `err_cnt_o=1`.
- **Reset mid-operation:** assert `wb_rst_i` after 4 bits with one word buffered -> all outputs are 0 immediately. A subsequent full word 0x01 emerges correctly.
- **Noise and saturation:**
  - Non-SOF strobes in IDLE -> ignored.
  - 300 framing errors -> `err_cnt_o=255`.
  - With `DESER_ERRCNT_EN` undefined -> `err_cnt_o=0` throughout.
